// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding and default bus widths for the MAR/MBR memory path
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_W = 4;
  localparam int TO_W = 8;
endpackage

// File: rtl/bus_wait_timer.sv
// bus_wait_timer: wait-state counter followed by a ready timeout counter, both saturating
module bus_wait_timer import mem_bus_pkg::*; #(
  parameter int WAIT_CYCLES = 1,
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr,
  input  logic run,
  input  logic ready,
  output logic wait_done,
  output logic timeout
);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  assign wait_done = wait_cnt_q == WAIT_W'(WAIT_CYCLES);
  assign timeout = to_cnt_q == TO_W'(TIMEOUT);
  // wait counts first; the timeout only starts once the wait states have elapsed
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    to_cnt_d = to_cnt_q;
    if (clr) begin
      wait_cnt_d = '0;
      to_cnt_d = '0;
    end else if (run) begin
      if (!wait_done) wait_cnt_d = wait_cnt_q + 1'b1;
      else if (!ready && !timeout) to_cnt_d = to_cnt_q + 1'b1;
    end
  end
  // counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: runs one RAM read/write per request with wait states and a ready timeout
module mem_bus_ctrl import mem_bus_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdata_valid,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  input  logic              i_ram_ready
);
  state_e state_q, state_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic access, wait_done, timeout;
  assign access = state_q == ACCESS;
  bus_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES), .TIMEOUT(TIMEOUT)) u_timer (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .clr(state_q == IDLE && i_req),
    .run(access),
    .ready(i_ram_ready),
    .wait_done(wait_done),
    .timeout(timeout)
  );
  assign o_busy = state_q != IDLE;
  assign o_err = state_q == ERR;
  assign o_done = state_q == RESP || o_err;
  assign o_rdata_valid = state_q == RESP && !we_q;
  assign o_rdata = o_rdata_valid ? rdata_q : '0;
  assign o_ram_en = access;
  assign o_ram_we = access && we_q;
  assign o_ram_addr = access ? addr_q : '0;
  assign o_ram_wdata = access ? wdata_q : '0;
  // next state and request/response latches; ready wins over timeout in the same cycle
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (i_req) begin
        state_d = ACCESS;
        we_d = i_we;
        addr_d = i_addr;
        wdata_d = i_wdata;
      end
      ACCESS: if (wait_done && i_ram_ready) begin
        state_d = RESP;
        if (!we_q) rdata_d = i_ram_rdata;
      end else if (wait_done && timeout) state_d = ERR;
      default: state_d = IDLE;
    endcase
  end
  // state and latch registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed checks of the memory bus controller against a simple RAM model
module tb_mem_bus_ctrl;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_req = 1'b0;
  logic i_we = 1'b0;
  logic [7:0] i_addr = '0;
  logic [15:0] i_wdata = '0;
  logic o_busy, o_done, o_err, o_rdata_valid, o_ram_en, o_ram_we, i_ram_ready;
  logic [15:0] o_rdata, o_ram_wdata, i_ram_rdata;
  logic [7:0] o_ram_addr;
  logic [15:0] ram [256];
  int en_cyc = 0;
  int mode = 0;
  int checks = 0;
  int errors = 0;

  mem_bus_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(1), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
    .o_rdata_valid(o_rdata_valid), .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata),
    .i_ram_ready(i_ram_ready)
  );

  always #5 i_clk = ~i_clk;

  // RAM model: mode 0 always ready, 1 ready in first enabled cycle and from the 6th on, 2 never
  assign i_ram_rdata = ram[o_ram_addr];
  assign i_ram_ready = mode == 0 ? 1'b1 : mode == 1 ? (en_cyc == 0 || en_cyc >= 5) : 1'b0;
  always @(posedge i_clk) begin
    en_cyc <= o_ram_en ? en_cyc + 1 : 0;
    if (o_ram_en && o_ram_we && i_ram_ready) ram[o_ram_addr] <= o_ram_wdata;
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0;
    ram[8'h3A] = 16'hBEEF;
    ram[8'h55] = 16'hA5A5;
  end

  // issue one request accepted at the next edge; returns in cycle 1 with inputs scrambled
  task automatic start(input logic we, input logic [7:0] a, input logic [15:0] d);
    @(negedge i_clk);
    i_req = 1'b1;
    i_we = we;
    i_addr = a;
    i_wdata = d;
    @(negedge i_clk);
    i_req = 1'b0;
    i_we = ~we;
    i_addr = 8'hFF;
    i_wdata = 16'hFFFF;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({o_busy, o_done, o_err, o_rdata_valid, o_ram_en, o_ram_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000", {o_busy, o_done, o_err, o_rdata_valid, o_ram_en, o_ram_we});
    end
    checks++;
    if ({o_rdata, o_ram_addr, o_ram_wdata} !== 40'h0) begin
      errors++;
      $display("FAIL reset_buses got %h want 0", {o_rdata, o_ram_addr, o_ram_wdata});
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_ram_en} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle got %b want 00", {o_busy, o_ram_en});
    end
  endtask

  task automatic test_read;
    logic [5:0] f;
    start(1'b0, 8'h3A, 16'h0);
    for (int c = 1; c <= 4; c++) begin
      f = {o_busy, o_done, o_err, o_rdata_valid, o_ram_en, o_ram_we};
      checks++;
      if (f !== (c <= 2 ? 6'b100010 : c == 3 ? 6'b110100 : 6'b000000)) begin
        errors++;
        $display("FAIL read_flags c%0d got %b", c, f);
      end
      checks++;
      if (o_ram_addr !== (c <= 2 ? 8'h3A : 8'h00)) begin
        errors++;
        $display("FAIL read_addr c%0d got %h", c, o_ram_addr);
      end
      checks++;
      if (o_rdata !== (c == 3 ? 16'hBEEF : 16'h0)) begin
        errors++;
        $display("FAIL read_rdata c%0d got %h", c, o_rdata);
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_write;
    logic [5:0] f;
    start(1'b1, 8'h10, 16'h1234);
    for (int c = 1; c <= 3; c++) begin
      f = {o_busy, o_done, o_err, o_rdata_valid, o_ram_en, o_ram_we};
      checks++;
      if (f !== (c <= 2 ? 6'b100011 : 6'b110000)) begin
        errors++;
        $display("FAIL write_flags c%0d got %b", c, f);
      end
      checks++;
      if ({o_ram_addr, o_ram_wdata, o_rdata} !== (c <= 2 ? {8'h10, 16'h1234, 16'h0} : 40'h0)) begin
        errors++;
        $display("FAIL write_bus c%0d got %h", c, {o_ram_addr, o_ram_wdata, o_rdata});
      end
      @(negedge i_clk);
    end
    start(1'b0, 8'h10, 16'h0);
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_done, o_rdata_valid, o_rdata} !== {2'b11, 16'h1234}) begin
      errors++;
      $display("FAIL write_readback got %b%b %h want 11 1234", o_done, o_rdata_valid, o_rdata);
    end
  endtask

  task automatic test_slow_ram;
    int ndone = 0;
    mode = 1;
    start(1'b0, 8'h55, 16'h0);
    for (int c = 1; c <= 8; c++) begin
      if (o_done === 1'b1) ndone++;
      checks++;
      if ({o_ram_en, o_done} !== {c <= 6, c == 7}) begin
        errors++;
        $display("FAIL slow_en_done c%0d got %b", c, {o_ram_en, o_done});
      end
      if (c == 7) begin
        checks++;
        if (o_rdata !== 16'hA5A5) begin
          errors++;
          $display("FAIL slow_rdata got %h want a5a5", o_rdata);
        end
      end
      @(negedge i_clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL slow_done_count got %0d want 1", ndone);
    end
    mode = 0;
  endtask

  task automatic test_timeout;
    mode = 2;
    start(1'b0, 8'h3A, 16'h0);
    for (int c = 1; c <= 19; c++) begin
      checks++;
      if ({o_ram_en, o_done, o_err, o_rdata_valid} !== {c <= 17, c == 18, c == 18, 1'b0}) begin
        errors++;
        $display("FAIL timeout_flags c%0d got %b", c, {o_ram_en, o_done, o_err, o_rdata_valid});
      end
      if (c == 18) begin
        checks++;
        if (o_rdata !== 16'h0) begin
          errors++;
          $display("FAIL timeout_rdata got %h want 0", o_rdata);
        end
      end
      @(negedge i_clk);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle busy got %b want 0", o_busy);
    end
    mode = 0;
  endtask

  task automatic test_req_while_busy;
    int ndone = 0;
    start(1'b0, 8'h3A, 16'h0);
    @(negedge i_clk);
    checks++;
    if ({o_ram_en, o_ram_addr} !== {1'b1, 8'h3A}) begin
      errors++;
      $display("FAIL busy_addr got %b %h want 1 3a", o_ram_en, o_ram_addr);
    end
    i_req = 1'b1;
    i_we = 1'b0;
    i_addr = 8'h20;
    @(negedge i_clk);
    i_req = 1'b0;
    checks++;
    if ({o_done, o_rdata} !== {1'b1, 16'hBEEF}) begin
      errors++;
      $display("FAIL busy_resp got %b %h want 1 beef", o_done, o_rdata);
    end
    for (int c = 3; c <= 6; c++) begin
      if (o_done === 1'b1) ndone++;
      if (c > 3) begin
        checks++;
        if ({o_busy, o_ram_en} !== 2'b00) begin
          errors++;
          $display("FAIL busy_ignored c%0d got %b want 00", c, {o_busy, o_ram_en});
        end
      end
      @(negedge i_clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL busy_done_count got %0d want 1", ndone);
    end
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    start(1'b0, 8'h10, 16'h0);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_ram_en, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_async got %b want 00", {o_ram_en, o_busy});
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      if (c == 1) i_rst_n = 1'b1;
      if (o_done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL rstmid_no_done got %0d want 0", ndone);
    end
    start(1'b0, 8'h10, 16'h0);
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_done, o_rdata_valid, o_rdata} !== {2'b11, 16'h1234}) begin
      errors++;
      $display("FAIL rstmid_fresh got %b%b %h want 11 1234", o_done, o_rdata_valid, o_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_slow_ram;
    test_timeout;
    test_req_while_busy;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
